rvx_spi_subordinate: RTL and testbench

SPI subordinate (target) endpoint: the responder for the SPI manager interface (`sclk`, `pico`, `poci`, `cs`) that the RVX SoC drives. It is SPI mode 0 (CPOL=0, CPHA=0), MSB first, full duplex. It oversamples the external SPI pins in the system clock domain and exchanges one word per `DATA_WIDTH` SCLK cycles through a valid/ready parallel interface. Its primary use is board-level loopback and co-processor bring-up.

---
 rtl/rvx_spi_subordinate.sv | 170 +++++++++++++++++
 tb/tb_rvx_spi_subordinate.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rvx_spi_subordinate.sv
// SPI mode-0 subordinate: oversampled pins, MSB-first full-duplex words over valid/ready.
// Latency: pin edges act two clocks after first sampling; rx_valid is registered one cycle after.
// Backpressure: one-entry TX holding buffer (tx_ready = empty); an empty buffer at load sends zeros.
module rvx_spi_subordinate #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic                  cs,
    output logic                  poci,
    output logic                  poci_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [1:0] sclk_sync_q, pico_sync_q, cs_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_s, pico_s, cs_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_count_q, bit_count_d;
    logic                  word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_underrun_q, tx_underrun_d;
    logic [DATA_WIDTH-1:0] buf_dat_q, buf_dat_d;
    logic                  buf_full_q, buf_full_d;
    logic                  word_load;
    logic                  buf_wr;
    logic [DATA_WIDTH-1:0] rx_next;

    assign sclk_s = sclk_sync_q[1];
    assign pico_s = pico_sync_q[1];
    assign cs_s   = cs_sync_q[1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign rx_next = {rx_shift_q[DATA_WIDTH-2:0], pico_s};
    assign buf_wr  = tx_valid & ~buf_full_q;

    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        word_done_d   = word_done_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_shift_d    = tx_shift_q;
        tx_underrun_d = 1'b0;
        buf_dat_d     = buf_dat_q;
        buf_full_d    = buf_full_q;
        word_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    bit_count_d = '0;
                    word_done_d = 1'b0;
                    word_load   = 1'b1;
                end
            end
            ACTIVE: begin
                // A cs edge takes priority over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d     = IDLE;
                    bit_count_d = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_count_q == CW'(DATA_WIDTH - 1)) begin
                        rx_data_d   = rx_next;
                        rx_valid_d  = 1'b1;
                        bit_count_d = '0;
                        word_done_d = 1'b1;
                    end else begin
                        bit_count_d = bit_count_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (word_done_q) begin
                        word_done_d = 1'b0;
                        word_load   = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The load sees the pre-write buffer state; a same-cycle write lands afterwards.
        if (word_load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_dat_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end

        if (buf_wr) begin
            buf_dat_d  = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q   <= 2'b00;
            pico_sync_q   <= 2'b00;
            cs_sync_q     <= 2'b11;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            state_q       <= IDLE;
            bit_count_q   <= '0;
            word_done_q   <= 1'b0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            tx_underrun_q <= 1'b0;
            buf_dat_q     <= '0;
            buf_full_q    <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[0], sclk};
            pico_sync_q   <= {pico_sync_q[0], pico};
            cs_sync_q     <= {cs_sync_q[0], cs};
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            word_done_q   <= word_done_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            tx_underrun_q <= tx_underrun_d;
            buf_dat_q     <= buf_dat_d;
            buf_full_q    <= buf_full_d;
        end
    end

    assign poci        = tx_shift_q[DATA_WIDTH-1];
    assign poci_oe     = ~cs_s;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_rvx_spi_subordinate.sv
// Directed bench for rvx_spi_subordinate acting as the SPI manager with SCLK = clock/8.
module tb_rvx_spi_subordinate;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       sclk     = 1'b0;
    logic       pico     = 1'b0;
    logic       cs       = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       poci, poci_oe, tx_ready, rx_valid, tx_underrun;
    logic [7:0] rx_data;

    rvx_spi_subordinate #(.DATA_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sclk       (sclk),
        .pico       (pico),
        .cs         (cs),
        .poci       (poci),
        .poci_oe    (poci_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         passed = 0;
    int         rx_cnt = 0;
    int         ur_cnt = 0;
    logic [7:0] rx_log[$];
    int         rx0, ur0;
    logic [7:0] m, m0, m1;

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_underrun) ur_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Manager side: drive pico in the low phase, sample poci just before raising SCLK.
    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            pico = mosi[7-i];
            tick(4);
            miso[7-i] = poci;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 300) begin
            tick(1);
            n++;
        end
        check("tx_ready_wait", 32'(n < 300), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_poci", poci, 0);
        check("rst_poci_oe", poci_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        reset_n = 1'b1;
        tick(3);

        // Single byte: 0xA5 out, 0x3C in
        rx0 = rx_cnt; ur0 = ur_cnt;
        write_tx(8'hA5);
        check("t1_ready_after_write", tx_ready, 0);
        cs_low();
        check("t1_poci_oe", poci_oe, 1);
        spi_bits(8'h3C, 8, m);
        cs_high();
        check("t1_miso", m, 8'hA5);
        check("t1_rx_pulses", rx_cnt - rx0, 1);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_tx_ready", tx_ready, 1);
        // the load after the final SCLK fall finds the buffer empty
        check("t1_trailing_underrun", ur_cnt - ur0, 1);

        // Back-to-back: 0x11,0x22 in; 0xF0,0x0F out; 0x55 covers the trailing load
        rx0 = rx_cnt; ur0 = ur_cnt;
        write_tx(8'hF0);
        fork
            begin
                cs_low();
                spi_bits(8'h11, 8, m0);
                spi_bits(8'h22, 8, m1);
                cs_high();
            end
            begin
                write_tx(8'h0F);
                write_tx(8'h55);
            end
        join
        check("t2_miso0", m0, 8'hF0);
        check("t2_miso1", m1, 8'h0F);
        check("t2_rx_pulses", rx_cnt - rx0, 2);
        check("t2_rx_word0", rx_log[rx0], 8'h11);
        check("t2_rx_word1", rx_log[rx0+1], 8'h22);
        check("t2_no_underrun", ur_cnt - ur0, 0);
        check("t2_tx_ready", tx_ready, 1);

        // Underrun at select
        rx0 = rx_cnt; ur0 = ur_cnt;
        cs_low();
        check("t3_select_underrun", ur_cnt - ur0, 1);
        spi_bits(8'h96, 8, m);
        cs_high();
        check("t3_miso_zero", m, 8'h00);
        check("t3_rx_data", rx_data, 8'h96);
        check("t3_rx_pulses", rx_cnt - rx0, 1);

        // Abort after 5 bits, then a clean 0x81 frame
        rx0 = rx_cnt;
        cs_low();
        spi_bits(8'hFF, 5, m);
        cs_high();
        check("t4_abort_no_rx", rx_cnt - rx0, 0);
        write_tx(8'h7E);
        cs_low();
        spi_bits(8'h81, 8, m);
        cs_high();
        check("t4_miso", m, 8'h7E);
        check("t4_rx_data", rx_data, 8'h81);
        check("t4_rx_pulses", rx_cnt - rx0, 1);

        // Async reset mid-frame
        write_tx(8'hC3);
        cs_low();
        write_tx(8'h3A);
        spi_bits(8'h00, 1, m);
        tick(4);
        check("t5_pre_poci", poci, 1);
        check("t5_pre_tx_ready", tx_ready, 0);
        check("t5_pre_poci_oe", poci_oe, 1);
        reset_n = 1'b0;
        cs      = 1'b1;
        #1;
        check("t5_rst_poci", poci, 0);
        check("t5_rst_poci_oe", poci_oe, 0);
        check("t5_rst_tx_ready", tx_ready, 1);
        check("t5_rst_rx_data", rx_data, 0);
        check("t5_rst_rx_valid", rx_valid, 0);
        check("t5_rst_tx_underrun", tx_underrun, 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        rx0 = rx_cnt;
        write_tx(8'h5A);
        cs_low();
        spi_bits(8'hE7, 8, m);
        cs_high();
        check("t5_post_miso", m, 8'h5A);
        check("t5_post_rx_data", rx_data, 8'hE7);
        check("t5_post_rx_pulses", rx_cnt - rx0, 1);

        // SCLK toggling while deselected
        write_tx(8'h99);
        rx0 = rx_cnt; ur0 = ur_cnt;
        pico = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            tick(4);
        end
        tick(4);
        check("t6_no_rx", rx_cnt - rx0, 0);
        check("t6_no_underrun", ur_cnt - ur0, 0);
        check("t6_poci_oe", poci_oe, 0);
        check("t6_no_load", tx_ready, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
